// File: rtl/imem_pkg.sv
// Types and defaults for the instruction-memory loader.
// Both imem_loader and imem_ram import this package.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 64;

  // mov r0,r0 -- harmless NOP returned for unloaded or out-of-range fetches
  localparam logic [31:0] NOP_FILL = 32'hE1A00000;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x WIDTH instruction RAM: one synchronous write port and one
// asynchronous (combinational) read port.
module imem_ram
  import imem_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset; stale words are masked by the loader's word count.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader and fetch port: streams a program into RAM, holds
// the core in reset until it is complete, then serves fetches by PC.
// Optional running checksum of loaded words: define IMEM_CHECKSUM_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned      WIDTH = DEF_WIDTH,
  parameter int unsigned      DEPTH = DEF_DEPTH,
  parameter logic [WIDTH-1:0] FILL  = WIDTH'(NOP_FILL),
  localparam int unsigned     AW    = $clog2(DEPTH),
  localparam int unsigned     CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reload,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_last,
  input  logic [31:0]      PC,
  output logic [WIDTH-1:0] Instr,
  output logic             cpu_reset,
  output logic [CW-1:0]    loaded,
  output logic             err,
  output logic [WIDTH-1:0] chk
);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_loaded;
  logic          r_cpu_reset;
  logic          r_err;

  logic          w_restart;
  logic          w_accept;
  logic [AW-1:0] w_idx;
  logic          w_hit;
  logic [WIDTH-1:0] w_rdata;
  logic          w_unused_pc;

  // reload is ignored in IDLE, which heads to LOAD on its own anyway
  assign w_restart = reload && (r_state != IDLE);
  assign ld_ready  = (r_state == LOAD) && !reload;
  assign w_accept  = ld_valid && ld_ready;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: w_next = LOAD;
      LOAD: begin
        if (w_accept) begin
          if (ld_last)                           w_next = RUN;
          else if (r_loaded == CW'(DEPTH - 1))   w_next = ERR;
        end
      end
      RUN:     w_next = RUN;
      ERR:     w_next = ERR;
      default: w_next = IDLE;
    endcase
    if (w_restart) w_next = LOAD;
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_loaded    <= '0;
      r_cpu_reset <= 1'b1;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cpu_reset <= (w_next != RUN);
      r_err       <= (w_next == ERR);
      if (w_restart)     r_loaded <= '0;
      else if (w_accept) r_loaded <= r_loaded + 1'b1;
    end
  end

`ifdef IMEM_CHECKSUM_EN
  logic [WIDTH-1:0] r_chk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_chk <= '0;
    else if (w_restart) r_chk <= '0;
    else if (w_accept)  r_chk <= r_chk + ld_data;
  end

  assign chk = r_chk;
`else
  assign chk = '0;
`endif

  imem_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (r_loaded[AW-1:0]),
    .i_wdata (ld_data),
    .i_raddr (w_idx),
    .o_rdata (w_rdata)
  );

  // Word-aligned fetch; words beyond the loaded count read as FILL.
  assign w_idx       = PC[AW+1:2];
  assign w_hit       = (PC[31:AW+2] == '0) && (CW'(w_idx) < r_loaded);
  assign w_unused_pc = ^PC[1:0];

  assign Instr     = w_hit ? w_rdata : FILL;
  assign cpu_reset = r_cpu_reset;
  assign loaded    = r_loaded;
  assign err       = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Scenario bench for imem_loader (DEPTH=4): expected program words are queued
// as they are streamed in and popped when fetched back by PC.
module tb_imem_loader;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] FILL  = 32'hE1A00000;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             reload = 1'b0;
  logic             ld_valid = 1'b0;
  logic             ld_ready;
  logic [WIDTH-1:0] ld_data = '0;
  logic             ld_last = 1'b0;
  logic [31:0]      PC = '0;
  logic [WIDTH-1:0] Instr;
  logic             cpu_reset;
  logic [CW-1:0]    loaded;
  logic             err;
  logic [WIDTH-1:0] chk;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_chk = '0;
  int               exp_loaded = 0;

  imem_loader #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .reload    (reload),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .PC        (PC),
    .Instr     (Instr),
    .cpu_reset (cpu_reset),
    .loaded    (loaded),
    .err       (err),
    .chk       (chk)
  );

  always #5 clk = ~clk;

  // Drive one word for one clock; returns ld_ready as seen before the edge.
  task automatic send_word(input logic [WIDTH-1:0] data, input logic last,
                           output logic rdy);
    ld_valid = 1'b1;
    ld_data  = data;
    ld_last  = last;
    #1;
    rdy = ld_ready;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Reference model update for a word the bench expects to be accepted.
  task automatic model_accept(input logic [WIDTH-1:0] data);
    exp_q.push_back(data);
    exp_loaded++;
`ifdef IMEM_CHECKSUM_EN
    exp_chk = exp_chk + data;
`endif
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_loaded = 0;
    exp_chk    = '0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL reset_cpu_reset got=%b exp=1", cpu_reset); end
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL reset_ld_ready got=%b exp=0", ld_ready); end
    checks++; if (loaded !== '0) begin failures++; $display("FAIL reset_loaded got=%0d exp=0", loaded); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (chk !== '0) begin failures++; $display("FAIL reset_chk got=%h exp=0", chk); end
    checks++; if (Instr !== FILL) begin failures++; $display("FAIL reset_instr got=%h exp=%h", Instr, FILL); end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL idle_to_load_ready got=%b exp=1", ld_ready); end
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL load_cpu_reset got=%b exp=1", cpu_reset); end
  endtask

  task automatic test_stream();
    logic [WIDTH-1:0] prog [3];
    logic rdy;
    prog[0] = 32'hE2833002;
    prog[1] = 32'hE1A04083;
    prog[2] = 32'hE2845001;
    for (int i = 0; i < 3; i++) begin
      send_word(prog[i], (i == 2), rdy);
      model_accept(prog[i]);
      checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL stream_ready_%0d got=%b exp=1", i, rdy); end
      checks++; if (loaded !== CW'(exp_loaded)) begin failures++; $display("FAIL stream_loaded_%0d got=%0d exp=%0d", i, loaded, exp_loaded); end
      checks++; if (cpu_reset !== (i != 2)) begin failures++; $display("FAIL stream_cpu_reset_%0d got=%b exp=%b", i, cpu_reset, (i != 2)); end
    end
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL run_ld_ready got=%b exp=0", ld_ready); end
    checks++; if (chk !== exp_chk) begin failures++; $display("FAIL stream_chk got=%h exp=%h", chk, exp_chk); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [WIDTH-1:0] w;
      w  = exp_q.pop_front();
      PC = 32'(i * 4);
      #1;
      checks++; if (Instr !== w) begin failures++; $display("FAIL stream_fetch_pc%0h got=%h exp=%h", PC, Instr, w); end
    end
    PC = 32'h5; #1;
    checks++; if (Instr !== 32'hE1A04083) begin failures++; $display("FAIL fetch_unaligned got=%h exp=E1A04083", Instr); end
    PC = 32'hC; #1;
    checks++; if (Instr !== FILL) begin failures++; $display("FAIL fetch_unloaded got=%h exp=%h", Instr, FILL); end
    PC = 32'h10; #1;
    checks++; if (Instr !== FILL) begin failures++; $display("FAIL fetch_out_of_range got=%h exp=%h", Instr, FILL); end
    PC = 32'h0;
  endtask

  task automatic test_reload();
    reload   = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 32'hDEADBEEF;
    #1;
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL reload_ready_gated got=%b exp=0", ld_ready); end
    @(posedge clk); #1;
    reload   = 1'b0;
    ld_valid = 1'b0;
    model_clear();
    #1;
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL reload_ready got=%b exp=1", ld_ready); end
    checks++; if (loaded !== '0) begin failures++; $display("FAIL reload_loaded got=%0d exp=0", loaded); end
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL reload_cpu_reset got=%b exp=1", cpu_reset); end
    checks++; if (chk !== '0) begin failures++; $display("FAIL reload_chk got=%h exp=0", chk); end
    PC = 32'h0; #1;
    checks++; if (Instr !== FILL) begin failures++; $display("FAIL reload_masked got=%h exp=%h", Instr, FILL); end
  endtask

  task automatic test_stall();
    logic rdy;
    send_word(32'hE3A01005, 1'b0, rdy);
    model_accept(32'hE3A01005);
    checks++; if (loaded !== CW'(exp_loaded)) begin failures++; $display("FAIL stall_loaded_a got=%0d exp=%0d", loaded, exp_loaded); end
    @(posedge clk); #1;
    checks++; if (loaded !== CW'(exp_loaded)) begin failures++; $display("FAIL stall_loaded_idle got=%0d exp=%0d", loaded, exp_loaded); end
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL stall_ready got=%b exp=1", ld_ready); end
    send_word(32'hE0812001, 1'b1, rdy);
    model_accept(32'hE0812001);
    checks++; if (loaded !== CW'(exp_loaded)) begin failures++; $display("FAIL stall_loaded_b got=%0d exp=%0d", loaded, exp_loaded); end
    checks++; if (cpu_reset !== 1'b0) begin failures++; $display("FAIL stall_cpu_reset got=%b exp=0", cpu_reset); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [WIDTH-1:0] w;
      w  = exp_q.pop_front();
      PC = 32'(i * 4);
      #1;
      checks++; if (Instr !== w) begin failures++; $display("FAIL reload_fetch_pc%0h got=%h exp=%h", PC, Instr, w); end
    end
    PC = 32'h8; #1;
    checks++; if (Instr !== FILL) begin failures++; $display("FAIL reload_fetch_pc8 got=%h exp=%h", Instr, FILL); end
  endtask

  task automatic test_overflow();
    logic rdy;
    pulse_reload();
    for (int i = 0; i < 4; i++) begin
      logic [WIDTH-1:0] w;
      w = 32'hA0000000 + 32'(i);
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL ovf_err_early_%0d got=%b exp=0", i, err); end
      send_word(w, 1'b0, rdy);
      model_accept(w);
      checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL ovf_ready_%0d got=%b exp=1", i, rdy); end
    end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL ovf_err got=%b exp=1", err); end
    checks++; if (loaded !== CW'(DEPTH)) begin failures++; $display("FAIL ovf_loaded got=%0d exp=%0d", loaded, DEPTH); end
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL ovf_cpu_reset got=%b exp=1", cpu_reset); end
    send_word(32'hBBBBBBBB, 1'b0, rdy);
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL ovf_fifth_ready got=%b exp=0", rdy); end
    checks++; if (loaded !== CW'(DEPTH)) begin failures++; $display("FAIL ovf_fifth_loaded got=%0d exp=%0d", loaded, DEPTH); end
    checks++; if (chk !== exp_chk) begin failures++; $display("FAIL ovf_chk got=%h exp=%h", chk, exp_chk); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [WIDTH-1:0] w;
      w  = exp_q.pop_front();
      PC = 32'(i * 4);
      #1;
      checks++; if (Instr !== w) begin failures++; $display("FAIL ovf_fetch_pc%0h got=%h exp=%h", PC, Instr, w); end
    end
  endtask

  task automatic test_reset_midload();
    logic rdy;
    pulse_reload();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_reload_clear got=%b exp=0", err); end
    send_word(32'h11111111, 1'b0, rdy);
    send_word(32'h22222222, 1'b0, rdy);
    checks++; if (loaded !== CW'(2)) begin failures++; $display("FAIL midload_loaded got=%0d exp=2", loaded); end
    #2 reset = 1'b1;
    #1;
    model_clear();
    checks++; if (loaded !== '0) begin failures++; $display("FAIL midload_rst_loaded got=%0d exp=0", loaded); end
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL midload_rst_ready got=%b exp=0", ld_ready); end
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL midload_rst_cpu_reset got=%b exp=1", cpu_reset); end
    PC = 32'h0; #1;
    checks++; if (Instr !== FILL) begin failures++; $display("FAIL midload_rst_instr got=%h exp=%h", Instr, FILL); end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    send_word(32'h12345678, 1'b1, rdy);
    model_accept(32'h12345678);
    checks++; if (cpu_reset !== 1'b0) begin failures++; $display("FAIL midload_new_cpu_reset got=%b exp=0", cpu_reset); end
    PC = 32'h0; #1;
    checks++; if (Instr !== exp_q.pop_front()) begin failures++; $display("FAIL midload_new_fetch got=%h exp=12345678", Instr); end
    PC = 32'h4; #1;
    checks++; if (Instr !== FILL) begin failures++; $display("FAIL midload_new_pc4 got=%h exp=%h", Instr, FILL); end
  endtask

  task automatic test_checksum();
    logic rdy;
    logic [WIDTH-1:0] want;
    pulse_reload();
    send_word(32'h00000001, 1'b0, rdy); model_accept(32'h00000001);
    send_word(32'h00000002, 1'b0, rdy); model_accept(32'h00000002);
    send_word(32'hFFFFFFFF, 1'b1, rdy); model_accept(32'hFFFFFFFF);
`ifdef IMEM_CHECKSUM_EN
    want = 32'h00000002;
`else
    want = 32'h00000000;
`endif
    checks++; if (chk !== want) begin failures++; $display("FAIL checksum got=%h exp=%h", chk, want); end
    checks++; if (chk !== exp_chk) begin failures++; $display("FAIL checksum_model got=%h exp=%h", chk, exp_chk); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (chk !== want) begin failures++; $display("FAIL checksum_hold got=%h exp=%h", chk, want); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_reload();
    test_stall();
    test_overflow();
    test_reset_midload();
    test_checksum();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
